// File: rtl/axi4lite_arbiter.sv
// Two-requester round-robin arbiter that sequences single-beat AXI4-Lite
// reads and writes into one shared slave and returns a completion pulse.
module axi4lite_arbiter #(
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              req_accept,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rvalid,
  output logic                    m_rready
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE
  } state_t;

  state_t state, state_nx;

  logic                  grant;
  logic                  last_grant;
  logic                  first;
  logic                  grant_c;
  logic                  start_c;
  logic [ADDR_WIDTH-1:0] sel_addr_c;
  logic [DATA_WIDTH-1:0] sel_wdata_c;
  logic                  unused_resp;

  // Contention goes to whoever did not win last; otherwise the lone requester.
  always_comb begin
    grant_c     = (&req_valid) ? ~last_grant : req_valid[1];
    start_c     = (state == IDLE) && (|req_valid);
    sel_addr_c  = grant_c ? req_addr[ADDR_WIDTH +: ADDR_WIDTH] : req_addr[0 +: ADDR_WIDTH];
    sel_wdata_c = grant_c ? req_wdata[DATA_WIDTH +: DATA_WIDTH] : req_wdata[0 +: DATA_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|req_valid) state_nx = req_write[grant_c] ? WR_REQ : RD_REQ;
      WR_REQ:  if ((!m_awvalid || m_awready) && (!m_wvalid || m_wready)) state_nx = WR_RESP;
      WR_RESP: if (m_bvalid) state_nx = DONE;
      RD_REQ:  if (m_arready) state_nx = RD_RESP;
      RD_RESP: if (m_rvalid) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request capture, AW/W valid tracking and response latching.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      first      <= 1'b0;
      m_awaddr   <= '0;
      m_wdata    <= '0;
      m_araddr   <= '0;
      m_awvalid  <= 1'b0;
      m_wvalid   <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      first <= 1'b0;
      if (start_c) begin
        grant      <= grant_c;
        last_grant <= grant_c;
        first      <= 1'b1;
        if (req_write[grant_c]) begin
          m_awaddr  <= sel_addr_c;
          m_wdata   <= sel_wdata_c;
          m_awvalid <= 1'b1;
          m_wvalid  <= 1'b1;
        end else begin
          m_araddr <= sel_addr_c;
        end
      end
      if (state == WR_REQ) begin
        if (m_awready) m_awvalid <= 1'b0;
        if (m_wready)  m_wvalid  <= 1'b0;
      end
      if (state == WR_RESP && m_bvalid) rsp_err <= m_bresp[1];
      if (state == RD_RESP && m_rvalid) begin
        rsp_rdata <= m_rdata;
        rsp_err   <= m_rresp[1];
      end
    end
  end

  assign busy        = (state != IDLE);
  assign m_arvalid   = (state == RD_REQ);
  assign m_bready    = (state == WR_RESP);
  assign m_rready    = (state == RD_RESP);
  assign m_wstrb     = {STRB_W{m_wvalid}};
  assign req_accept  = first ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_valid   = (state == DONE) ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign unused_resp = ^{m_bresp[0], m_rresp[0]};

endmodule

// File: tb/tb_axi4lite_arbiter.sv
// Directed bench for axi4lite_arbiter with a small register-file slave model.
module tb_axi4lite_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid, req_write;
  logic [3:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0] req_accept, rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err, busy;
  logic [1:0] m_awaddr, m_araddr;
  logic       m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic       m_arvalid, m_arready, m_rvalid, m_rready;
  logic [7:0] m_wdata, m_rdata;
  logic [0:0] m_wstrb;
  logic [1:0] m_bresp, m_rresp;

  always #5 clk = ~clk;

  axi4lite_arbiter #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_accept(req_accept), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  // Slave model: 4 x 8-bit registers, configurable AW stall, SLVERR on addr 3, optional read hold.
  logic [7:0] mem [4];
  int         aw_stall, aw_cnt;
  logic       err_en, r_block, have_aw, have_w;
  logic [1:0] aw_a, wa;
  logic [7:0] w_d, wd;
  logic       aw_hs, w_hs;

  assign m_awready = (aw_cnt >= aw_stall);
  assign m_wready  = 1'b1;
  assign m_arready = 1'b1;
  assign aw_hs     = m_awvalid && m_awready;
  assign w_hs      = m_wvalid && m_wready;
  assign wa        = aw_hs ? m_awaddr : aw_a;
  assign wd        = w_hs ? m_wdata : w_d;

  always @(posedge clk) begin
    if (rst) begin
      have_aw <= 1'b0; have_w <= 1'b0; aw_cnt <= 0; aw_a <= '0; w_d <= '0;
      m_bvalid <= 1'b0; m_bresp <= '0; m_rvalid <= 1'b0; m_rdata <= '0; m_rresp <= '0;
    end else begin
      if (m_awvalid && !m_awready) aw_cnt <= aw_cnt + 1;
      else if (aw_hs)              aw_cnt <= 0;
      if (m_bvalid && m_bready) m_bvalid <= 1'b0;
      if (aw_hs) begin have_aw <= 1'b1; aw_a <= m_awaddr; end
      if (w_hs)  begin have_w  <= 1'b1; w_d  <= m_wdata;  end
      if ((have_aw || aw_hs) && (have_w || w_hs)) begin
        mem[wa]  <= wd;
        m_bvalid <= 1'b1;
        m_bresp  <= (err_en && wa == 2'd3) ? 2'b10 : 2'b00;
        have_aw  <= 1'b0;
        have_w   <= 1'b0;
      end
      if (m_rvalid && m_rready) m_rvalid <= 1'b0;
      if (m_arvalid && m_arready && !r_block) begin
        m_rvalid <= 1'b1;
        m_rdata  <= mem[m_araddr];
        m_rresp  <= 2'b00;
      end
    end
  end

  // Event counters sampled mid-cycle.
  int   acc1_cnt = 0, rsp0_cnt = 0, aw_hi = 0, w_hi = 0, awaddr_bad = 0, strb_bad = 0;
  logic bp_on;
  always @(negedge clk) begin
    if (req_accept[1]) acc1_cnt <= acc1_cnt + 1;
    if (rsp_valid[0])  rsp0_cnt <= rsp0_cnt + 1;
    if (m_awvalid)     aw_hi <= aw_hi + 1;
    if (m_wvalid)      w_hi <= w_hi + 1;
    if (bp_on && m_awvalid && m_awaddr != 2'd1) awaddr_bad <= awaddr_bad + 1;
    if (m_wvalid && m_wstrb != 1'b1) strb_bad <= strb_bad + 1;
  end

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin @(negedge clk); n++; end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic run_req(input int i, input logic wr, input logic [1:0] a, input logic [7:0] d,
                         output logic [7:0] rd, output logic er);
    int   n = 0;
    logic ok;
    req_write[i] = wr;
    req_addr[i*2 +: 2] = a;
    req_wdata[i*8 +: 8] = d;
    req_valid[i] = 1'b1;
    do begin @(negedge clk); n++; end while (!req_accept[i] && n < 50);
    ok = req_accept[i];
    req_valid[i] = 1'b0;
    n = 0;
    while (!rsp_valid[i] && n < 50) begin @(negedge clk); n++; end
    ok = ok & rsp_valid[i];
    rd = rsp_rdata;
    er = rsp_err;
    check("req_done", 32'(ok), 32'd1);
  endtask

  logic [1:0] seq [4];
  logic [7:0] rd;
  logic       er;
  int         k, n, s_acc1, s_rsp0, s_aw, s_w;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    aw_stall = 0; err_en = 1'b0; r_block = 1'b0; bp_on = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ctrl", {26'd0, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, busy}, 32'd0);
    check("rst_pulses", {28'd0, req_accept, rsp_valid}, 32'd0);
    check("rst_rsp", {23'd0, rsp_err, rsp_rdata}, 32'd0);
    check("rst_last_grant", 32'(dut.last_grant), 32'd1);
    rst = 1'b0;

    // Contention right after reset: 0 first, then alternate while both held.
    foreach (seq[j]) seq[j] = 2'd3;
    req_valid = 2'b11;
    k = 0; n = 0;
    while (k < 4 && n < 200) begin
      @(negedge clk); n++;
      if (req_accept[0])      begin seq[k] = 2'd0; k++; end
      else if (req_accept[1]) begin seq[k] = 2'd1; k++; end
    end
    req_valid = 2'b00;
    check("cont_count", 32'(k), 32'd4);
    for (int j = 0; j < 4; j++) check($sformatf("cont_grant%0d", j), 32'(seq[j]), 32'(j % 2));
    wait_idle();

    // Write then read from requester 0.
    @(negedge clk);
    s_acc1 = acc1_cnt; s_rsp0 = rsp0_cnt;
    run_req(0, 1'b1, 2'd2, 8'h04, rd, er);
    check("wr_err", 32'(er), 32'd0);
    run_req(0, 1'b0, 2'd2, 8'h00, rd, er);
    check("rd_data", 32'(rd), 32'h04);
    check("rd_err", 32'(er), 32'd0);
    wait_idle();
    repeat (2) @(negedge clk);
    check("wr_rd_rsp0_count", 32'(rsp0_cnt - s_rsp0), 32'd2);
    check("wr_rd_no_accept1", 32'(acc1_cnt - s_acc1), 32'd0);

    // Back-pressure: awready held low 3 cycles, wready immediate.
    aw_stall = 3; bp_on = 1'b1;
    s_aw = aw_hi; s_w = w_hi; s_rsp0 = rsp0_cnt;
    run_req(0, 1'b1, 2'd1, 8'h5A, rd, er);
    wait_idle();
    repeat (2) @(negedge clk);
    bp_on = 1'b0; aw_stall = 0;
    check("bp_awvalid_cycles", 32'(aw_hi - s_aw), 32'd4);
    check("bp_wvalid_cycles", 32'(w_hi - s_w), 32'd1);
    check("bp_awaddr_stable", 32'(awaddr_bad), 32'd0);
    check("bp_rsp_count", 32'(rsp0_cnt - s_rsp0), 32'd1);
    check("wstrb_ones", 32'(strb_bad), 32'd0);
    run_req(0, 1'b0, 2'd1, 8'h00, rd, er);
    check("bp_readback", 32'(rd), 32'h5A);

    // Error response to requester 1, then a clean read clears rsp_err.
    err_en = 1'b1;
    run_req(1, 1'b1, 2'd3, 8'hEE, rd, er);
    check("err_set", 32'(er), 32'd1);
    run_req(1, 0, 2'd2, 8'h00, rd, er);
    check("err_cleared", 32'(er), 32'd0);
    check("err_rd_data", 32'(rd), 32'h04);
    err_en = 1'b0;
    wait_idle();

    // Reset while waiting in RD_RESP with rvalid low.
    r_block = 1'b1;
    req_write[0] = 1'b0; req_addr[1:0] = 2'd2; req_valid[0] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_accept[0] && n < 50);
    req_valid[0] = 1'b0;
    n = 0;
    while (!m_rready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    check("mid_rd_resp", 32'(m_rready), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ctrl", {26'd0, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, busy}, 32'd0);
    check("mid_rst_pulses", {28'd0, req_accept, rsp_valid}, 32'd0);
    check("mid_rst_rsp", {23'd0, rsp_err, rsp_rdata}, 32'd0);
    check("mid_rst_addr", {12'd0, m_awaddr, m_araddr, m_wdata, 8'd0}, 32'd0);
    check("mid_rst_last_grant", 32'(dut.last_grant), 32'd1);
    rst = 1'b0; r_block = 1'b0;
    run_req(0, 1'b0, 2'd2, 8'h00, rd, er);
    check("post_rst_rd", 32'(rd), 32'h04);
    wait_idle();

    // Latency with a zero-wait slave.
    @(negedge clk);
    req_write[0] = 1'b1; req_addr[1:0] = 2'd0; req_wdata[7:0] = 8'h11; req_valid[0] = 1'b1;
    @(negedge clk);
    check("lat_c1_accept", {30'd0, req_accept}, 32'd1);
    check("lat_c1_busy", 32'(busy), 32'd1);
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("lat_c2_bready", {29'd0, m_bready, rsp_valid}, 32'h4);
    @(negedge clk);
    check("lat_c3_rsp", {30'd0, rsp_valid}, 32'd1);
    @(negedge clk);
    check("lat_c4_idle", {29'd0, busy, rsp_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4lite_arbiter.md
# axi4lite_arbiter

Two-requester round-robin arbiter and AXI4-Lite master sequencer. It sits in front of the existing AXI4-Lite slave register file (ADDR_WIDTH=2, DATA_WIDTH=8) and shares that slave between two independent requesters. It takes one single-beat read or write request at a time, drives the AW/W/B or AR/R channel handshakes, and returns a one-cycle completion pulse with read data and error status to the granted requester.

## Interface
Parameters:
- ADDR_WIDTH, 2, AXI address width
- DATA_WIDTH, 8, AXI data width; must be a multiple of 8

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  2  request pending; bit i is requester i; held until req_accept[i]
- req_write  in  2  1 = write, 0 = read, per requester
- req_addr  in  2*ADDR_WIDTH  requester i address at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  2*DATA_WIDTH  requester i write data at [i*DATA_WIDTH +: DATA_WIDTH]
- req_accept  out  2  one-cycle pulse: request latched, requester may drop/change inputs
- rsp_valid  out  2  one-cycle completion pulse to the granted requester
- rsp_rdata  out  DATA_WIDTH  read data; valid with rsp_valid on reads; held until the next read completion
- rsp_err  out  1  1 = SLVERR/DECERR (resp[1] set); valid with rsp_valid
- busy  out  1  high in every state except IDLE
- m_awaddr / m_awvalid (out) / m_awready (in): write address channel
- m_wdata / m_wstrb (out, DATA_WIDTH/8, all ones while wvalid) / m_wvalid (out) / m_wready (in)
- m_bresp (in, 2) / m_bvalid (in) / m_bready (out)
- m_araddr / m_arvalid (out) / m_arready (in)
- m_rdata (in) / m_rresp (in, 2) / m_rvalid (in) / m_rready (out)

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE: if any req_valid is set, choose the grant g:
  - only one requester valid: grant that one;
  - both valid: grant the requester that is not last_grant.
- On grant, register g, write, addr and wdata, set last_grant<=g, and go to WR_REQ or RD_REQ.
- WR_REQ:
  - req_accept[g]=1 on the first cycle only;
  - m_awvalid and m_wvalid rise together, and each drops independently after its own handshake (valid&ready at a clock edge);
  - go to WR_RESP when both handshakes are done, including the case where both complete in the same cycle.
- WR_RESP: m_bready=1. On m_bvalid, latch rsp_err=m_bresp[1] and go to DONE.
- RD_REQ:
  - req_accept[g]=1 on the first cycle only;
  - m_arvalid=1 until m_arready, then go to RD_RESP.
- RD_RESP: m_rready=1. On m_rvalid, latch rsp_rdata=m_rdata and rsp_err=m_rresp[1], then go to DONE.
- DONE: rsp_valid[g]=1 for exactly one cycle, then IDLE. A request that is already pending can be granted in the following IDLE cycle.
- Channel rules:
  - valid signals never drop before their handshake;
  - address and data outputs stay stable while their valid is high;
  - bready and rready are low outside their response states.
- No timeout. A slave that never responds leaves the block in its wait state until rst.
- rst mid-transaction: the next cycle is IDLE with all valid/ready/accept/rsp outputs at 0. The slave must be reset alongside this block.

## Timing
- Reset values:
  - state=IDLE, last_grant=1 (requester 0 wins the first contention);
  - rsp_rdata=0, rsp_err=0, busy=0;
  - req_accept=0, rsp_valid=0;
  - all m_*valid=0, m_bready=0, m_rready=0;
  - m_awaddr, m_wdata, m_araddr = 0.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.
- Zero-wait slave (ready high; bvalid/rvalid one cycle after the address/data handshake):
  - cycle 0: IDLE sees req_valid;
  - cycle 1: WR_REQ/RD_REQ;
  - cycle 2: response state;
  - cycle 3: DONE;
  - minimum 4 cycles request-to-IDLE.
- req_valid must stay high until req_accept. A request deasserted before that is not guaranteed to be served.

## Test plan
- Write then read, one requester: req0 writes addr 2, data 0x04; then req0 reads addr 2. Required: rsp_valid[0] twice, rsp_rdata=0x04, rsp_err=0, req_accept[1] never set.
- Contention: both requesters request on the same cycle right after reset, and again on the next opportunity. Required: requester 0 is served first; the next contention grants requester 1; grants alternate while both are held.
- Back-pressure: slave holds awready low for 3 cycles while wready is immediate. Required: m_wvalid drops after 1 cycle; m_awvalid is held 4 cycles with m_awaddr stable; exactly one rsp_valid.
- Error response: slave returns bresp=2'b10 on a write to addr 3 from requester 1. Required: rsp_valid[1]=1 with rsp_err=1; the next successful read clears rsp_err to 0.
- Reset mid-operation: assert rst while in RD_RESP with rvalid low. Required: next cycle all outputs at reset values and last_grant=1; a new request after reset completes normally.
- Latency: zero-wait slave, single write. Required: req_accept in cycle 1, rsp_valid in cycle 3, busy low in cycle 4.
